// File: rtl/axil_reg_bank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
// Response codes, channel FSM state encodings and address-width helper.
package axil_reg_bank_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Index bits plus byte-offset bits, never narrower than 3.
  function automatic int calc_addr_w(input int num_regs, input int data_w);
    int w;
    w = $clog2(num_regs) + $clog2(data_w / 8);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/axil_reg_bank_wch.sv
// Write-channel FSM: independent AW/W capture, byte-strobe merge and B response.
// The register array itself lives in the top; this block only says what to write where.
module axil_reg_bank_wch
  import axil_reg_bank_pkg::*;
#(
  parameter int                      DW      = 32,
  parameter int                      NR      = 4,
  parameter logic [NR-1:0]           RO_MASK = '0,
  parameter int                      IDX_W   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IDX_W-1:0]           awidx_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DW-1:0]              wdata_i,
  input  logic [DW/8-1:0]            wstrb_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [NR-1:0][DW-1:0]      regs_i,
  output logic                       wr_en_o,
  output logic [IDX_W-1:0]           wr_idx_o,
  output logic [DW-1:0]              wr_val_o
);

  localparam int            STRB_W = DW / 8;
  localparam logic [IDX_W:0] NR_L  = (IDX_W + 1)'(NR);

  wstate_e           state_q, state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [IDX_W-1:0]  awidx_q, awidx_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              aw_fire, w_fire, do_wr;
  logic [IDX_W-1:0]  idx_cur;
  logic [DW-1:0]     data_cur, cur_val;
  logic [STRB_W-1:0] strb_cur;
  logic              in_range, ro_hit;

  assign awready_o = rst_ni && (state_q == W_IDLE) && !aw_held_q;
  assign wready_o  = rst_ni && (state_q == W_IDLE) && !w_held_q;
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = bresp_q;

  // A held beat takes priority: a channel cannot fire while its beat is held.
  assign idx_cur  = aw_held_q ? awidx_q : awidx_i;
  assign data_cur = w_held_q  ? wdata_q : wdata_i;
  assign strb_cur = w_held_q  ? wstrb_q : wstrb_i;

  assign in_range = {1'b0, idx_cur} < NR_L;
  assign ro_hit   = in_range && RO_MASK[idx_cur];
  assign cur_val  = in_range ? regs_i[idx_cur] : '0;

  always_comb begin
    wr_val_o = cur_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb_cur[k]) wr_val_o[k*8 +: 8] = data_cur[k*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    do_wr     = 1'b0;
    case (state_q)
      W_IDLE: begin
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          do_wr     = 1'b1;
          state_d   = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = (in_range && !ro_hit) ? OKAY : SLVERR;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awidx_d   = awidx_i;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
            wstrb_d  = wstrb_i;
          end
        end
      end
      W_RESP: begin
        if (bready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // An all-zero strobe still completes with OKAY but touches nothing.
  assign wr_en_o  = do_wr && in_range && !ro_hit && (|strb_cur);
  assign wr_idx_o = idx_cur;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank with per-register read-only status sourcing.
// Holds the register array, the read channel and the write strobe pulses.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0]   C_RO_MASK    = '0,
  localparam int                     C_ADDR_WIDTH = calc_addr_w(C_NUM_REGS, C_DATA_WIDTH)
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]              AWADDR,
  input  logic [2:0]                           AWPROT,
  input  logic                                 AWVALID,
  output logic                                 AWREADY,
  input  logic [C_DATA_WIDTH-1:0]              WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]            WSTRB,
  input  logic                                 WVALID,
  output logic                                 WREADY,
  output logic [1:0]                           BRESP,
  output logic                                 BVALID,
  input  logic                                 BREADY,
  input  logic [C_ADDR_WIDTH-1:0]              ARADDR,
  input  logic [2:0]                           ARPROT,
  input  logic                                 ARVALID,
  output logic                                 ARREADY,
  output logic [C_DATA_WIDTH-1:0]              RDATA,
  output logic [1:0]                           RRESP,
  output logic                                 RVALID,
  input  logic                                 RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   status_in,
  output logic [C_NUM_REGS-1:0]                wr_strobe
);

  localparam int             BYTE_W = $clog2(C_DATA_WIDTH / 8);
  localparam int             IDX_W  = C_ADDR_WIDTH - BYTE_W;
  localparam logic [IDX_W:0] NR_L   = (IDX_W + 1)'(C_NUM_REGS);

  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] regs_q, status_a;
  logic [C_NUM_REGS-1:0]                   wr_strobe_q, wr_strobe_d;
  logic                                    wr_en;
  logic [IDX_W-1:0]                        wr_idx;
  logic [C_DATA_WIDTH-1:0]                 wr_val;

  rstate_e                 rstate_q, rstate_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [IDX_W-1:0]        ar_idx;
  logic                    ar_fire, ar_in_range, ar_ro;

  // Protection bits and byte offsets carry no meaning for this bank.
  logic unused_addr;
  assign unused_addr = ^{AWPROT, ARPROT, AWADDR[BYTE_W-1:0], ARADDR[BYTE_W-1:0]};

  assign status_a  = status_in;
  assign reg_out   = regs_q;
  assign wr_strobe = wr_strobe_q;

  axil_reg_bank_wch #(
    .DW      (C_DATA_WIDTH),
    .NR      (C_NUM_REGS),
    .RO_MASK (C_RO_MASK),
    .IDX_W   (IDX_W)
  ) u_wch (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .awidx_i   (AWADDR[C_ADDR_WIDTH-1:BYTE_W]),
    .awvalid_i (AWVALID),
    .awready_o (AWREADY),
    .wdata_i   (WDATA),
    .wstrb_i   (WSTRB),
    .wvalid_i  (WVALID),
    .wready_o  (WREADY),
    .bresp_o   (BRESP),
    .bvalid_o  (BVALID),
    .bready_i  (BREADY),
    .regs_i    (regs_q),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_val_o  (wr_val)
  );

  always_comb begin
    wr_strobe_d = '0;
    if (wr_en) wr_strobe_d[wr_idx] = 1'b1;
  end

  // Read-only slots are never enabled for write, so they stay at reset zero.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      regs_q      <= '0;
      wr_strobe_q <= '0;
    end else begin
      wr_strobe_q <= wr_strobe_d;
      if (wr_en) regs_q[wr_idx] <= wr_val;
    end
  end

  assign ar_idx      = ARADDR[C_ADDR_WIDTH-1:BYTE_W];
  assign ar_in_range = {1'b0, ar_idx} < NR_L;
  assign ar_ro       = ar_in_range && C_RO_MASK[ar_idx];
  assign ARREADY     = ARESETN && (rstate_q == R_IDLE);
  assign ar_fire     = ARVALID && ARREADY;
  assign RVALID      = (rstate_q == R_DATA);
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;

  // regs_q is sampled before any same-edge write lands, giving pre-write data.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_fire) begin
          rstate_d = R_DATA;
          if (!ar_in_range) begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end else begin
            rdata_d = ar_ro ? status_a[ar_idx] : regs_q[ar_idx];
            rresp_d = OKAY;
          end
        end
      end
      R_DATA: begin
        if (RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank (32-bit, 6 regs, reg 5 read-only).
// Expected B/R responses are queued at issue and popped when the DUT answers.
module tb_axil_reg_bank;
  import axil_reg_bank_pkg::*;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = calc_addr_w(NR, DW);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [AW-1:0]     AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, AWREADY, WVALID, WREADY;
  logic [DW-1:0]     WDATA, RDATA;
  logic [DW/8-1:0]   WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [NR*DW-1:0]  reg_out, status_in;
  logic [NR-1:0]     wr_strobe;

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  int          scnt[NR];
  int          s_before[NR];

  axil_reg_bank #(
    .C_DATA_WIDTH (DW),
    .C_NUM_REGS   (NR),
    .C_RO_MASK    (6'b100000)
  ) dut (
    .ACLK (ACLK), .ARESETN (ARESETN),
    .AWADDR (AWADDR), .AWPROT (AWPROT), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
    .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARADDR (ARADDR), .ARPROT (ARPROT), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
    .reg_out (reg_out), .status_in (status_in), .wr_strobe (wr_strobe)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) scnt[i] += int'(wr_strobe[i]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rslice(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  task automatic snap();
    for (int i = 0; i < NR; i++) s_before[i] = scnt[i];
  endtask

  task automatic wr_issue(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead, input logic [1:0] exp);
    bit aw_hs, w_hs, aw_done, w_done;
    aw_done = 0; w_done = 0;
    bq.push_back(exp);
    @(negedge ACLK);
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == lead) begin AWADDR = a; AWVALID = 1'b1; end
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin WVALID = 1'b0; w_done = 1; end
      if (aw_done && w_done) break;
      @(negedge ACLK);
    end
    if (!(aw_done && w_done)) chk("aw_w_accept_timeout", {aw_done, w_done}, 2'b11);
  endtask

  task automatic wr_resp(input string tag);
    bit got = 0;
    logic [1:0] e;
    @(negedge ACLK);
    BREADY = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (BVALID) begin
        got = 1;
        e = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        chk(tag, BRESP, e);
      end
      @(posedge ACLK); #1;
      if (got) break;
      @(negedge ACLK);
    end
    BREADY = 1'b0;
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic rd_issue(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] r);
    bit done = 0;
    rq.push_back('{data: d, resp: r});
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      done = ARREADY;
      @(posedge ACLK); #1;
      if (done) begin ARVALID = 1'b0; break; end
      @(negedge ACLK);
    end
    if (!done) chk("ar_accept_timeout", 0, 1);
  endtask

  task automatic rd_resp(input string tag);
    bit got = 0;
    rexp_t e;
    @(negedge ACLK);
    chk({tag, "_latency"}, RVALID, 1'b1);
    RREADY = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (RVALID) begin
        got = 1;
        e = (rq.size() > 0) ? rq.pop_front() : '{data: 'x, resp: 'x};
        chk({tag, "_data"}, RDATA, e.data);
        chk({tag, "_resp"}, RRESP, e.resp);
      end
      @(posedge ACLK); #1;
      if (got) break;
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] r,
                    input string tag);
    rd_issue(a, d, r);
    rd_resp(tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp, input string tag);
    wr_issue(a, d, s, 0, exp);
    wr_resp(tag);
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = 3'b010; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARPROT = 3'b001; ARVALID = 0; RREADY = 0;
    status_in = {32'hDEADBEEF, {5{32'hA5A5A5A5}}};

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_valids", {BVALID, RVALID}, 2'b00);
    chk("rst_resp_rdata", {BRESP, RRESP, RDATA}, '0);
    chk("rst_reg_out", reg_out, '0);
    chk("rst_strobe", wr_strobe, '0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Basic write/readback of the writable registers
    for (int i = 0; i < 4; i++) wr(AW'(i*4), 32'(i+1), 4'hF, OKAY, "wr_basic_bresp");
    for (int i = 0; i < 4; i++) chk("reg_out_basic", rslice(i), 32'(i+1));
    for (int i = 0; i < 4; i++) rd(AW'(i*4), 32'(i+1), OKAY, "rd_basic");

    // Partial byte strobe merges into the existing value
    wr(AW'(0), 32'h1, 4'hF, OKAY, "wr_r0_init");
    snap();
    wr(AW'(0), 32'hAABBCCDD, 4'b0010, OKAY, "wr_strb_bresp");
    chk("strobe0_once", scnt[0] - s_before[0], 1);
    chk("strobe_others", (scnt[1]+scnt[2]+scnt[3]+scnt[4]+scnt[5]) -
        (s_before[1]+s_before[2]+s_before[3]+s_before[4]+s_before[5]), 0);
    rd(AW'(0), 32'h0000CC01, OKAY, "rd_strb");

    // Zero strobe: OKAY, no change, no pulse
    snap();
    wr(AW'(4), 32'hFFFFFFFF, 4'h0, OKAY, "wr_nostrb_bresp");
    chk("nostrb_no_pulse", scnt[1] - s_before[1], 0);
    rd(AW'(4), 32'h2, OKAY, "rd_nostrb");

    // W leads AW by three cycles
    snap();
    wr_issue(AW'(8), 32'h33, 4'hF, 3, OKAY);
    wr_resp("wr_wfirst_bresp");
    @(negedge ACLK);
    chk("wfirst_single_bvalid", BVALID, 0);
    chk("wfirst_strobe_once", scnt[2] - s_before[2], 1);
    rd(AW'(8), 32'h33, OKAY, "rd_wfirst");

    // Read-only and out-of-range addresses
    snap();
    wr(AW'(5'h14), 32'h11, 4'hF, SLVERR, "wr_ro_bresp");
    chk("ro_no_pulse", scnt[5] - s_before[5], 0);
    rd(AW'(5'h14), 32'hDEADBEEF, OKAY, "rd_ro");
    chk("reg_out_ro_zero", rslice(5), 0);
    wr(AW'(5'h18), 32'h22, 4'hF, SLVERR, "wr_oor_bresp");
    rd(AW'(5'h18), 32'h0, SLVERR, "rd_oor");
    rd(AW'(5'h1C), 32'h0, SLVERR, "rd_oor_top");

    // B backpressure: second write must wait for the B handshake
    wr_issue(AW'(12), 32'h55, 4'hF, 0, OKAY);
    @(negedge ACLK);
    AWADDR = AW'(12); AWVALID = 1'b1; WDATA = 32'h66; WSTRB = 4'hF; WVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_bvalid", BVALID, 1);
      chk("bp_bresp", BRESP, OKAY);
      chk("bp_readies", {AWREADY, WREADY}, 2'b00);
      @(negedge ACLK);
    end
    chk("bp_reg_held", rslice(3), 32'h55);
    wr_resp("bp_bresp_first");
    wr_issue(AW'(12), 32'h66, 4'hF, 0, OKAY);
    wr_resp("bp_bresp_second");
    rd(AW'(12), 32'h66, OKAY, "rd_bp");

    // Same-cycle read and write of one register returns the old value
    ARADDR = AW'(0); ARVALID = 1'b1;
    rq.push_back('{data: 32'h0000CC01, resp: OKAY});
    wr_issue(AW'(0), 32'h12345678, 4'hF, 0, OKAY);
    ARVALID = 1'b0;
    rd_resp("rd_prewrite");
    wr_resp("wr_concurrent_bresp");
    rd(AW'(0), 32'h12345678, OKAY, "rd_postwrite");

    // Reset with both responses pending
    ARADDR = AW'(8); ARVALID = 1'b1;
    rq.push_back('{data: 32'h33, resp: OKAY});
    wr_issue(AW'(4), 32'h77, 4'hF, 0, OKAY);
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_valids", {BVALID, RVALID}, 2'b11);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    chk("midrst_valids", {BVALID, RVALID}, 2'b00);
    chk("midrst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("midrst_resp_rdata", {BRESP, RRESP, RDATA}, '0);
    chk("midrst_reg_out", reg_out, '0);
    chk("midrst_strobe", wr_strobe, '0);
    ARESETN = 1'b1;
    bq.delete();
    rq.delete();
    @(negedge ACLK);
    chk("rel_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    chk("rel_valids", {BVALID, RVALID}, 2'b00);
    rd(AW'(4), 32'h0, OKAY, "rd_after_rst");

    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
